// File: rtl/flex_counter_pkg.sv
// Shared types for the multi-channel flex counter.
// Optional sticky rollover capture is enabled by defining ROLLOVER_STICKY_EN.
package flex_counter_pkg;

    typedef enum logic [1:0] {
        CNT_WRAP    = 2'b00,
        CNT_SAT     = 2'b01,
        CNT_ONESHOT = 2'b10,
        CNT_RSVD    = 2'b11
    } cnt_mode_t;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } ch_state_t;

endpackage

// File: rtl/flex_counter_ch.sv
// One counter channel: count, terminal flag, run/halt state.
// Defining ROLLOVER_STICKY_EN adds a sticky rollover bit with its own clear.
module flex_counter_ch
    import flex_counter_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         en_i,
    input  logic         down_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic [W-1:0] roll_val_i,
    input  logic [1:0]   mode_i,
`ifdef ROLLOVER_STICKY_EN
    input  logic         sticky_clr_i,
    output logic         sticky_o,
`endif
    output logic [W-1:0] count_o,
    output logic         flag_o
);

    localparam logic [W-1:0] ZERO = '0;
    localparam logic [W-1:0] ONE  = W'(1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         flag_q, flag_d;
    ch_state_t    st_q, st_d;
    logic [W-1:0] term;
    logic         halt_now;

    assign term = down_i ? ZERO : roll_val_i;

    always_comb begin
        cnt_d    = cnt_q;
        flag_d   = flag_q;
        st_d     = st_q;
        halt_now = 1'b0;
        if (clear_i) begin
            cnt_d  = ZERO;
            flag_d = 1'b0;
            st_d   = RUN;
        end else if (load_i) begin
            cnt_d  = load_val_i;
            flag_d = (load_val_i == term);
            st_d   = RUN;
        end else if (en_i && st_q == RUN) begin
            if (roll_val_i == ZERO) begin
                flag_d = 1'b0;
            end else begin
                // Terminal checks come first so +1/-1 never wraps modulo 2^W.
                if (!down_i) begin
                    if (cnt_q < roll_val_i) begin
                        cnt_d = cnt_q + ONE;
                    end else begin
                        case (cnt_mode_t'(mode_i))
                            CNT_SAT:     cnt_d = roll_val_i;
                            CNT_ONESHOT: begin
                                cnt_d    = ZERO;
                                halt_now = 1'b1;
                            end
                            default:     cnt_d = ONE;
                        endcase
                    end
                end else begin
                    if (cnt_q != ZERO) begin
                        cnt_d = cnt_q - ONE;
                    end else begin
                        case (cnt_mode_t'(mode_i))
                            CNT_SAT:     cnt_d = ZERO;
                            CNT_ONESHOT: halt_now = 1'b1;
                            default:     cnt_d = roll_val_i;
                        endcase
                    end
                end
                st_d   = halt_now ? HALT : RUN;
                flag_d = !halt_now && (cnt_d == term);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= ZERO;
            flag_q <= 1'b0;
            st_q   <= RUN;
        end else begin
            cnt_q  <= cnt_d;
            flag_q <= flag_d;
            st_q   <= st_d;
        end
    end

`ifdef ROLLOVER_STICKY_EN
    logic sticky_q, sticky_d;

    // A rising flag wins over a same-cycle clear.
    assign sticky_d = (flag_d && !flag_q) || (sticky_q && !sticky_clr_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sticky_q <= 1'b0;
        else       sticky_q <= sticky_d;
    end

    assign sticky_o = sticky_q;
`endif

    assign count_o = cnt_q;
    assign flag_o  = flag_q;

endmodule

// File: rtl/flex_counter_mc.sv
// NUM_CH independent flex counters with packed I/O and a global rollover OR.
// Defining ROLLOVER_STICKY_EN adds sticky_clr/rollover_sticky per channel.
module flex_counter_mc
    import flex_counter_pkg::*;
#(
    parameter int NUM_CNT_BITS = 4,
    parameter int NUM_CH       = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            clear,
    input  logic [NUM_CH-1:0]            count_enable,
    input  logic [NUM_CH-1:0]            count_down,
    input  logic [NUM_CH-1:0]            load,
    input  logic [NUM_CH*NUM_CNT_BITS-1:0] load_val,
    input  logic [NUM_CH*NUM_CNT_BITS-1:0] rollover_val,
    input  logic [NUM_CH*2-1:0]          mode,
`ifdef ROLLOVER_STICKY_EN
    input  logic [NUM_CH-1:0]            sticky_clr,
    output logic [NUM_CH-1:0]            rollover_sticky,
`endif
    output logic [NUM_CH*NUM_CNT_BITS-1:0] count_out,
    output logic [NUM_CH-1:0]            rollover_flag,
    output logic                         any_rollover
);

    localparam int W = NUM_CNT_BITS;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        flex_counter_ch #(.W(W)) u_ch (
            .clk_i        (clk),
            .rst_i        (rst),
            .clear_i      (clear[c]),
            .en_i         (count_enable[c]),
            .down_i       (count_down[c]),
            .load_i       (load[c]),
            .load_val_i   (load_val[c*W +: W]),
            .roll_val_i   (rollover_val[c*W +: W]),
            .mode_i       (mode[2*c +: 2]),
`ifdef ROLLOVER_STICKY_EN
            .sticky_clr_i (sticky_clr[c]),
            .sticky_o     (rollover_sticky[c]),
`endif
            .count_o      (count_out[c*W +: W]),
            .flag_o       (rollover_flag[c])
        );
    end

`ifdef ROLLOVER_STICKY_EN
    assign any_rollover = |rollover_sticky;
`else
    assign any_rollover = |rollover_flag;
`endif

endmodule

// File: tb/tb_flex_counter_mc.sv
// Randomized and directed bench for flex_counter_mc against a behavioural model.
// Builds with or without ROLLOVER_STICKY_EN.
module tb_flex_counter_mc;

    localparam int W   = 4;
    localparam int NCH = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [NCH-1:0]     clear, count_enable, count_down, load;
    logic [NCH*W-1:0]   load_val, rollover_val, count_out;
    logic [NCH*2-1:0]   mode;
    logic [NCH-1:0]     rollover_flag;
    logic               any_rollover;
`ifdef ROLLOVER_STICKY_EN
    logic [NCH-1:0]     sticky_clr, rollover_sticky;
`endif

    int n_vec = 0;
    int n_err = 0;

    int m_cnt[NCH];
    bit m_flag[NCH];
    bit m_halt[NCH];
    bit m_sticky[NCH];

    flex_counter_mc #(.NUM_CNT_BITS(W), .NUM_CH(NCH)) dut (
        .clk             (clk),
        .rst             (rst),
        .clear           (clear),
        .count_enable    (count_enable),
        .count_down      (count_down),
        .load            (load),
        .load_val        (load_val),
        .rollover_val    (rollover_val),
        .mode            (mode),
`ifdef ROLLOVER_STICKY_EN
        .sticky_clr      (sticky_clr),
        .rollover_sticky (rollover_sticky),
`endif
        .count_out       (count_out),
        .rollover_flag   (rollover_flag),
        .any_rollover    (any_rollover)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        n_vec++;
        if (obs !== 32'(exp)) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_cnt[c]    = 0;
            m_flag[c]   = 0;
            m_halt[c]   = 0;
            m_sticky[c] = 0;
        end
    endtask

    task automatic model_edge();
        for (int c = 0; c < NCH; c++) begin
            int rv, lv, md, term;
            bit dn, old_flag, halt_now, sclr;
            rv       = int'(rollover_val[c*W +: W]);
            lv       = int'(load_val[c*W +: W]);
            md       = int'(mode[2*c +: 2]);
            dn       = count_down[c];
            term     = dn ? 0 : rv;
            old_flag = m_flag[c];
            halt_now = 0;
            if (clear[c]) begin
                m_cnt[c] = 0; m_flag[c] = 0; m_halt[c] = 0;
            end else if (load[c]) begin
                m_cnt[c] = lv; m_halt[c] = 0; m_flag[c] = (lv == term);
            end else if (count_enable[c] && !m_halt[c]) begin
                if (rv == 0) begin
                    m_flag[c] = 0;
                end else begin
                    if (!dn) begin
                        if (m_cnt[c] < rv)  m_cnt[c] = m_cnt[c] + 1;
                        else if (md == 1)   m_cnt[c] = rv;
                        else if (md == 2)   begin m_cnt[c] = 0; halt_now = 1; end
                        else                m_cnt[c] = 1;
                    end else begin
                        if (m_cnt[c] > 0)   m_cnt[c] = m_cnt[c] - 1;
                        else if (md == 2)   halt_now = 1;
                        else if (md != 1)   m_cnt[c] = rv;
                    end
                    m_halt[c] = halt_now;
                    m_flag[c] = halt_now ? 1'b0 : (m_cnt[c] == term);
                end
            end
`ifdef ROLLOVER_STICKY_EN
            sclr = sticky_clr[c];
`else
            sclr = 1'b1;
`endif
            m_sticky[c] = (m_flag[c] && !old_flag) || (m_sticky[c] && !sclr);
        end
    endtask

    task automatic check_all(input string tag);
        bit any_exp;
        any_exp = 0;
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("%s cnt%0d", tag, c), 32'(count_out[c*W +: W]), m_cnt[c]);
            chk($sformatf("%s flag%0d", tag, c), 32'(rollover_flag[c]), int'(m_flag[c]));
`ifdef ROLLOVER_STICKY_EN
            chk($sformatf("%s sticky%0d", tag, c), 32'(rollover_sticky[c]), int'(m_sticky[c]));
            any_exp |= m_sticky[c];
`else
            any_exp |= m_flag[c];
`endif
        end
        chk($sformatf("%s any", tag), 32'(any_rollover), int'(any_exp));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        clear        = '0;
        count_enable = '0;
        load         = '0;
`ifdef ROLLOVER_STICKY_EN
        sticky_clr   = '0;
`endif
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1 model_reset();
        check_all(tag);
        rst = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        count_down   = '0;
        load_val     = '0;
        rollover_val = '0;
        mode         = '0;
        idle();
        model_reset();
        #12;
        check_all("reset");
        rst = 1'b0;

        // wrap up to 5 on ch0, ch1 idle, then async reset mid-count
        rollover_val[0 +: W] = 4'd5;
        count_enable         = 2'b01;
        for (int i = 0; i < 7; i++) step("wrap_up");
        async_reset("async_rst");
        for (int i = 0; i < 2; i++) step("post_rst");

        // wrap down from load 2
        idle();
        count_down[0]    = 1'b1;
        load_val[0 +: W] = 4'd2;
        load[0]          = 1'b1;
        step("load_dn");
        idle();
        count_enable[0] = 1'b1;
        for (int i = 0; i < 4; i++) step("wrap_dn");

        // saturate up on ch1, then reverse
        idle();
        mode[2 +: 2]         = 2'b01;
        rollover_val[W +: W] = 4'd3;
        count_enable[1]      = 1'b1;
        for (int i = 0; i < 5; i++) step("sat_up");
        count_down[1] = 1'b1;
        step("sat_dn");

        // one-shot up on ch0, reload after halt
        idle();
        clear[0] = 1'b1;
        step("clr");
        idle();
        count_down[0]        = 1'b0;
        mode[0 +: 2]         = 2'b10;
        rollover_val[0 +: W] = 4'd2;
        count_enable[0]      = 1'b1;
        for (int i = 0; i < 5; i++) step("oneshot");
        load_val[0 +: W] = 4'd1;
        load[0]          = 1'b1;
        step("os_load");
        load[0] = 1'b0;
        step("os_run");

        // clear beats load beats enable; zero rollover ignores steps
        clear[0] = 1'b1; load[0] = 1'b1;
        step("prio");
        idle();
        rollover_val[0 +: W] = 4'd0;
        count_enable[0]      = 1'b1;
        for (int i = 0; i < 2; i++) step("rv0");

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            for (int c = 0; c < NCH; c++) begin
                clear[c]        = ($urandom_range(15) == 0);
                load[c]         = ($urandom_range(9) == 0);
                count_enable[c] = ($urandom_range(3) != 0);
                if ($urandom_range(7) == 0) count_down[c] = $urandom_range(1);
                if ($urandom_range(15) == 0) mode[2*c +: 2] = 2'($urandom_range(3));
                if ($urandom_range(19) == 0)
                    rollover_val[c*W +: W] = W'($urandom_range(15));
                load_val[c*W +: W] = W'($urandom_range(15));
`ifdef ROLLOVER_STICKY_EN
                sticky_clr[c] = ($urandom_range(5) == 0);
`endif
            end
            if ($urandom_range(59) == 0) async_reset("rnd_rst");
            else step("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
